oc0a_perst_ctrl: RTL and testbench
==================================

Name: oc0a_perst_ctrl

Overview:
- Drives fundamental reset (PERST#) for the downstream NVMe device on the oc0a link; this is the sourcing end of the same PERST# signal the card receives from its host.
- Holds the device in reset for a programmed interval after refclk is stable, releases it, and waits for link-up. On link-up timeout or link loss it retries a bounded number of times, then parks in a fail state.
- Sits between the board-level host_perstn / refclk status and the oc0a root-port core inside the block design.

Parameters:
- T_PERST_CYCLES, 25000000, cycles PERST# stays low after refclk lock (100 ms at 250 MHz)
- T_LINK_TIMEOUT, 25000000, cycles allowed after release for link_up to assert
- MAX_RETRIES, 3, retries before FAIL; legal range 0..15
- LINKDN_FILTER, 16, consecutive link_up=0 cycles in UP that count as link loss

Ports:
- aclk  in  1  sole clock
- aresetn  in  1  synchronous active-low reset
- host_perstn  in  1  board PERST# from upstream host; asynchronous, synchronised internally
- refclk_locked  in  1  oc0a refclk/GT PLL locked
- link_up  in  1  root-port data-link-up
- sw_reset_req  in  1  single-cycle request to restart the sequence
- oc0a_perstn  out  1  PERST# to device, registered
- rp_resetn  out  1  root-port core reset, registered
- link_ready  out  1  high while in UP
- link_fail  out  1  high while in FAIL
- retry_cnt  out  4  retries consumed since last clear
- state  out  2  ASSERT=0, RELEASE=1, UP=2, FAIL=3

Behaviour:
- Reset (aresetn=0 at an aclk edge):
  - state=ASSERT, oc0a_perstn=0, rp_resetn=0, link_ready=0, link_fail=0, retry_cnt=0.
  - Cycle counter and filter counter cleared; both synchroniser flops cleared to 0.
  - Reset mid-operation aborts immediately to this condition.
- host_perstn passes through a 2-flop synchroniser, giving hp_s; latency 2 cycles.
- Global priorities, evaluated every cycle, highest first:
  1. aresetn=0.
  2. hp_s=0: next state ASSERT, counter=0, retry_cnt=0.
  3. sw_reset_req=1: same effect as priority 2.
  4. Per-state logic below.
- Outputs are registered from next state:
  - oc0a_perstn=1 and rp_resetn=1 only in RELEASE or UP.
  - link_ready=1 only in UP; link_fail=1 only in FAIL.
- ASSERT:
  - Counter increments each cycle refclk_locked=1.
  - refclk_locked=0 clears the counter to 0, so the lock must hold continuously.
  - Counter == T_PERST_CYCLES-1 with lock -> RELEASE, counter=0.
  - oc0a_perstn therefore rises exactly T_PERST_CYCLES cycles after the first locked cycle.
- RELEASE:
  - Counter increments each cycle.
  - link_up=1 -> UP. This wins over a same-cycle timeout.
  - Counter == T_LINK_TIMEOUT-1 with link_up=0 and retry_cnt < MAX_RETRIES -> retry_cnt+1, ASSERT, counter=0.
  - Same timeout with retry_cnt == MAX_RETRIES -> FAIL.
  - refclk_locked=0 -> ASSERT, no retry charged.
- UP:
  - Filter counter increments while link_up=0 and clears on link_up=1.
  - Filter reaching LINKDN_FILTER -> link loss, handled with the same retry/FAIL rule as a timeout.
  - A drop of LINKDN_FILTER-1 cycles has no effect.
  - refclk_locked=0 -> ASSERT, no retry charged.
- FAIL: stays in FAIL until priority 2 or 3 fires; refclk_locked and link_up are ignored.
- Widths and limits:
  - Counter width is clog2 of max(T_PERST_CYCLES, T_LINK_TIMEOUT).
  - retry_cnt never exceeds MAX_RETRIES.
  - MAX_RETRIES=0 means the first timeout goes straight to FAIL.

Test Plan (T_PERST_CYCLES=16, T_LINK_TIMEOUT=32, MAX_RETRIES=2, LINKDN_FILTER=4):
- Reset, then hp_s=1, refclk_locked=1, link_up raised 10 cycles after release -> oc0a_perstn rises 16 cycles after lock; state=UP and link_ready=1 one cycle after link_up; retry_cnt=0.
- Lock drops at ASSERT cycle 10 and returns -> oc0a_perstn rises 16 cycles after lock returns, not earlier.
- link_up never asserts -> two 16+32-cycle release attempts (retry_cnt 1 then 2), then the third timeout gives state=FAIL, link_fail=1, oc0a_perstn=0. A sw_reset_req pulse returns to ASSERT with retry_cnt=0.
- In UP, link_up low for 3 cycles -> stays UP. Low for 4 cycles -> ASSERT, retry_cnt=1, oc0a_perstn=0 next cycle.
- host_perstn pulled low during RELEASE -> ASSERT 2–3 cycles later, retry_cnt cleared. In RELEASE, link_up rising on the timeout cycle -> UP, no retry charged.
- aresetn low mid-UP for one cycle -> all outputs at reset values the next cycle, and the sequence restarts.

Source files
------------

// File: rtl/oc0a_perst_ctrl.sv
// oc0a_perst_ctrl
// Sources PERST# for the downstream NVMe device on the oc0a link. After refclk has
// been continuously locked for T_PERST_CYCLES, the device and root-port core are
// released. The block then waits up to T_LINK_TIMEOUT cycles for data-link-up.
// A link-up timeout, or a filtered link loss while up, is retried up to MAX_RETRIES
// times. After that the block parks in FAIL until host PERST# or a software restart.
//
// Ports:
//   i_aclk            sole clock
//   i_aresetn         synchronous active-low reset
//   i_host_perstn     upstream host PERST# (asynchronous, synchronised here)
//   i_refclk_locked   refclk / GT PLL locked
//   i_link_up         root-port data-link-up
//   i_sw_reset_req    single-cycle request to restart the sequence
//   o_oc0a_perstn     PERST# to the device (registered)
//   o_rp_resetn       root-port core reset (registered)
//   o_link_ready      high while in UP
//   o_link_fail       high while in FAIL
//   o_retry_cnt       retries consumed since the last clear
//   o_state           ASSERT=0, RELEASE=1, UP=2, FAIL=3

module oc0a_perst_ctrl #(
    parameter int unsigned T_PERST_CYCLES = 25000000,
    parameter int unsigned T_LINK_TIMEOUT = 25000000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned LINKDN_FILTER  = 16
) (
    input  logic       i_aclk,
    input  logic       i_aresetn,
    input  logic       i_host_perstn,
    input  logic       i_refclk_locked,
    input  logic       i_link_up,
    input  logic       i_sw_reset_req,
    output logic       o_oc0a_perstn,
    output logic       o_rp_resetn,
    output logic       o_link_ready,
    output logic       o_link_fail,
    output logic [3:0] o_retry_cnt,
    output logic [1:0] o_state
);

    localparam int unsigned CntMax  = (T_PERST_CYCLES > T_LINK_TIMEOUT) ?
                                      T_PERST_CYCLES : T_LINK_TIMEOUT;
    localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
    // The filter only needs to hold 0..LINKDN_FILTER-1; the last value triggers loss.
    localparam int unsigned FiltW   = (LINKDN_FILTER > 1) ? $clog2(LINKDN_FILTER) : 1;

    localparam logic [CntW-1:0]  PerstLast = CntW'(T_PERST_CYCLES - 1);
    localparam logic [CntW-1:0]  LinkLast  = CntW'(T_LINK_TIMEOUT - 1);
    localparam logic [FiltW-1:0] FiltLast  = FiltW'(LINKDN_FILTER - 1);
    localparam logic [3:0]       RetryMax  = 4'(MAX_RETRIES);

    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StRelease = 2'd1,
        StUp      = 2'd2,
        StFail    = 2'd3
    } state_e;

    state_e           r_state;
    logic [CntW-1:0]  r_cnt;
    logic [FiltW-1:0] r_filt;
    logic [3:0]       r_retry;
    logic             r_hp_meta;
    logic             r_hp_s;
    logic             r_perstn;
    logic             r_rp_resetn;
    logic             r_ready;
    logic             r_fail;

    state_e           w_state_nxt;
    logic [CntW-1:0]  w_cnt_nxt;
    logic [FiltW-1:0] w_filt_nxt;
    logic [3:0]       w_retry_nxt;
    logic             w_retry_ok;

    assign w_retry_ok = (r_retry < RetryMax);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_filt_nxt  = r_filt;
        w_retry_nxt = r_retry;

        if (!r_hp_s || i_sw_reset_req) begin
            // Host PERST# or software restart: full restart, retry budget refilled.
            w_state_nxt = StAssert;
            w_cnt_nxt   = '0;
            w_filt_nxt  = '0;
            w_retry_nxt = '0;
        end else begin
            unique case (r_state)
                StAssert: begin
                    w_filt_nxt = '0;
                    if (!i_refclk_locked) begin
                        // Lock must hold continuously for the whole interval.
                        w_cnt_nxt = '0;
                    end else if (r_cnt == PerstLast) begin
                        w_state_nxt = StRelease;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end

                StRelease: begin
                    if (!i_refclk_locked) begin
                        w_state_nxt = StAssert;
                        w_cnt_nxt   = '0;
                    end else if (i_link_up) begin
                        // Link-up beats a timeout landing in the same cycle.
                        w_state_nxt = StUp;
                        w_cnt_nxt   = '0;
                        w_filt_nxt  = '0;
                    end else if (r_cnt == LinkLast) begin
                        w_cnt_nxt = '0;
                        if (w_retry_ok) begin
                            w_retry_nxt = r_retry + 4'd1;
                            w_state_nxt = StAssert;
                        end else begin
                            w_state_nxt = StFail;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end

                StUp: begin
                    if (!i_refclk_locked) begin
                        w_state_nxt = StAssert;
                        w_cnt_nxt   = '0;
                        w_filt_nxt  = '0;
                    end else if (i_link_up) begin
                        w_filt_nxt = '0;
                    end else if (r_filt == FiltLast) begin
                        // LINKDN_FILTER consecutive low cycles: treat as link loss.
                        w_cnt_nxt  = '0;
                        w_filt_nxt = '0;
                        if (w_retry_ok) begin
                            w_retry_nxt = r_retry + 4'd1;
                            w_state_nxt = StAssert;
                        end else begin
                            w_state_nxt = StFail;
                        end
                    end else begin
                        w_filt_nxt = r_filt + FiltW'(1);
                    end
                end

                StFail: begin
                    w_cnt_nxt  = '0;
                    w_filt_nxt = '0;
                end

                default: begin
                    w_state_nxt = StAssert;
                    w_cnt_nxt   = '0;
                    w_filt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_state     <= StAssert;
            r_cnt       <= '0;
            r_filt      <= '0;
            r_retry     <= '0;
            r_hp_meta   <= 1'b0;
            r_hp_s      <= 1'b0;
            r_perstn    <= 1'b0;
            r_rp_resetn <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_hp_meta   <= i_host_perstn;
            r_hp_s      <= r_hp_meta;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_filt      <= w_filt_nxt;
            r_retry     <= w_retry_nxt;
            // Outputs are decoded from the next state so they line up with r_state.
            r_perstn    <= (w_state_nxt == StRelease) || (w_state_nxt == StUp);
            r_rp_resetn <= (w_state_nxt == StRelease) || (w_state_nxt == StUp);
            r_ready     <= (w_state_nxt == StUp);
            r_fail      <= (w_state_nxt == StFail);
        end
    end

    assign o_oc0a_perstn = r_perstn;
    assign o_rp_resetn   = r_rp_resetn;
    assign o_link_ready  = r_ready;
    assign o_link_fail   = r_fail;
    assign o_retry_cnt   = r_retry;
    assign o_state       = r_state;

endmodule

// File: tb/tb_oc0a_perst_ctrl.sv
// Testbench for oc0a_perst_ctrl: directed walk through the bring-up scenarios
// followed by randomized stimulus, every cycle compared against a behavioural model.

module tb_oc0a_perst_ctrl;

    localparam int unsigned TP = 16;
    localparam int unsigned TL = 32;
    localparam int unsigned MR = 2;
    localparam int unsigned LF = 4;

    logic       clk;
    logic       aresetn;
    logic       host_perstn;
    logic       refclk_locked;
    logic       link_up;
    logic       sw_reset_req;
    logic       oc0a_perstn;
    logic       rp_resetn;
    logic       link_ready;
    logic       link_fail;
    logic [3:0] retry_cnt;
    logic [1:0] state;

    int n_tests;
    int n_fail;
    int cyc;

    // Reference model state
    int m_st;
    int m_run;
    int m_age;
    int m_low;
    int m_retry;
    int m_hp1;
    int m_hp2;

    oc0a_perst_ctrl #(
        .T_PERST_CYCLES (TP),
        .T_LINK_TIMEOUT (TL),
        .MAX_RETRIES    (MR),
        .LINKDN_FILTER  (LF)
    ) u_dut (
        .i_aclk          (clk),
        .i_aresetn       (aresetn),
        .i_host_perstn   (host_perstn),
        .i_refclk_locked (refclk_locked),
        .i_link_up       (link_up),
        .i_sw_reset_req  (sw_reset_req),
        .o_oc0a_perstn   (oc0a_perstn),
        .o_rp_resetn     (rp_resetn),
        .o_link_ready    (link_ready),
        .o_link_fail     (link_fail),
        .o_retry_cnt     (retry_cnt),
        .o_state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_to_assert();
        m_st  = 0;
        m_run = 0;
    endtask

    // Link never came up, or was lost: spend a retry if any remain, else give up.
    task automatic m_link_lost();
        if (m_retry < int'(MR)) begin
            m_retry++;
            m_to_assert();
        end else begin
            m_st = 3;
        end
    endtask

    task automatic m_edge(input logic rn, input logic h, input logic l, input logic u,
                          input logic s);
        int hp_s;
        if (!rn) begin
            m_st = 0; m_run = 0; m_age = 0; m_low = 0; m_retry = 0; m_hp1 = 0; m_hp2 = 0;
            return;
        end
        hp_s  = m_hp2;
        m_hp2 = m_hp1;
        m_hp1 = int'(h);
        if (hp_s == 0 || s) begin
            m_to_assert();
            m_retry = 0;
        end else begin
            case (m_st)
                0: begin
                    m_run = l ? m_run + 1 : 0;
                    if (m_run == int'(TP)) begin
                        m_st  = 1;
                        m_age = 0;
                    end
                end
                1: begin
                    if (!l) m_to_assert();
                    else if (u) begin
                        m_st  = 2;
                        m_low = 0;
                    end else begin
                        m_age++;
                        if (m_age == int'(TL)) m_link_lost();
                    end
                end
                2: begin
                    if (!l) m_to_assert();
                    else begin
                        m_low = u ? 0 : m_low + 1;
                        if (m_low == int'(LF)) m_link_lost();
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: inputs already stable, model follows the edge, outputs checked 1ns later.
    task automatic tick(input logic sw);
        sw_reset_req = sw;
        @(posedge clk);
        m_edge(aresetn, host_perstn, refclk_locked, link_up, sw);
        #1;
        sw_reset_req = 1'b0;
        chk("state",      32'(state),       32'(m_st));
        chk("perstn",     32'(oc0a_perstn), 32'(m_st == 1 || m_st == 2));
        chk("rp_resetn",  32'(rp_resetn),   32'(m_st == 1 || m_st == 2));
        chk("link_ready", 32'(link_ready),  32'(m_st == 2));
        chk("link_fail",  32'(link_fail),   32'(m_st == 3));
        chk("retry_cnt",  32'(retry_cnt),   32'(m_retry));
    endtask

    task automatic wait_perst_rise(input int bound, output int n);
        n = 0;
        while (!oc0a_perstn && n < bound) begin
            tick(1'b0);
            n++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_st = 0; m_run = 0; m_age = 0; m_low = 0; m_retry = 0; m_hp1 = 0; m_hp2 = 0;
        aresetn       = 1'b0;
        host_perstn   = 1'b1;
        refclk_locked = 1'b1;
        link_up       = 1'b0;
        sw_reset_req  = 1'b0;

        // Reset state
        tick(1'b0);
        tick(1'b0);
        chk("rst_state",  32'(state), 32'd0);
        chk("rst_perstn", 32'(oc0a_perstn), 32'd0);
        chk("rst_retry",  32'(retry_cnt), 32'd0);

        // Bring-up: 2 cycles of synchroniser latency, then 16 locked cycles
        aresetn = 1'b1;
        wait_perst_rise(40, cyc);
        chk("bringup_cycles", 32'(cyc), 32'd18);
        repeat (9) tick(1'b0);
        link_up = 1'b1;
        tick(1'b0);
        chk("up_state", 32'(state), 32'd2);
        chk("up_ready", 32'(link_ready), 32'd1);

        // Link drop shorter than the filter is ignored; a full-length one is a loss
        link_up = 1'b0;
        repeat (3) tick(1'b0);
        link_up = 1'b1;
        tick(1'b0);
        chk("short_drop_state", 32'(state), 32'd2);
        link_up = 1'b0;
        repeat (4) tick(1'b0);
        chk("loss_state",  32'(state), 32'd0);
        chk("loss_retry",  32'(retry_cnt), 32'd1);
        chk("loss_perstn", 32'(oc0a_perstn), 32'd0);

        // Link never comes up: three 16+32 attempts, then FAIL
        tick(1'b1);
        cyc = 0;
        while (!link_fail && cyc < 300) begin
            tick(1'b0);
            cyc++;
        end
        chk("fail_cycles", 32'(cyc), 32'd144);
        chk("fail_state",  32'(state), 32'd3);
        chk("fail_retry",  32'(retry_cnt), 32'd2);
        tick(1'b1);
        chk("swrst_state", 32'(state), 32'd0);
        chk("swrst_retry", 32'(retry_cnt), 32'd0);

        // Lock lost at ASSERT cycle 10: the full interval restarts
        repeat (10) tick(1'b0);
        refclk_locked = 1'b0;
        tick(1'b0);
        refclk_locked = 1'b1;
        wait_perst_rise(40, cyc);
        chk("relock_cycles", 32'(cyc), 32'd16);

        // One timeout to charge a retry, then host PERST# during RELEASE clears it
        repeat (32) tick(1'b0);
        chk("timeout_retry", 32'(retry_cnt), 32'd1);
        wait_perst_rise(40, cyc);
        chk("retry_release_cycles", 32'(cyc), 32'd16);
        host_perstn = 1'b0;
        cyc = 0;
        while (state != 2'd0 && cyc < 10) begin
            tick(1'b0);
            cyc++;
        end
        chk("hp_latency", 32'(cyc), 32'd3);
        chk("hp_retry",   32'(retry_cnt), 32'd0);

        // link_up arriving on the timeout cycle wins
        host_perstn = 1'b1;
        wait_perst_rise(60, cyc);
        chk("hp_release_cycles", 32'(cyc), 32'd18);
        repeat (31) tick(1'b0);
        link_up = 1'b1;
        tick(1'b0);
        chk("edge_up_state", 32'(state), 32'd2);
        chk("edge_up_retry", 32'(retry_cnt), 32'd0);

        // One-cycle reset mid-UP
        aresetn = 1'b0;
        tick(1'b0);
        chk("midrst_state",  32'(state), 32'd0);
        chk("midrst_perstn", 32'(oc0a_perstn), 32'd0);
        chk("midrst_ready",  32'(link_ready), 32'd0);
        aresetn = 1'b1;
        link_up = 1'b0;
        wait_perst_rise(40, cyc);
        chk("restart_cycles", 32'(cyc), 32'd18);

        // Randomized traffic: rare resets / lock loss, bursty link_up
        for (int i = 0; i < 4000; i++) begin
            aresetn       = ($urandom_range(0, 499) != 0);
            host_perstn   = ($urandom_range(0, 199) != 0);
            refclk_locked = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0) link_up = ~link_up;
            tick($urandom_range(0, 399) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
